// File: rtl/mmss_timer_core.sv
// MM:SS up/down timer core with start/stop/clear/load commands, tick prescaler,
// wrap/expiry pulses and registered 2-digit BCD outputs for each field.
module mmss_timer_core #(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 99,
    parameter int TICK_DIV = 1,
    localparam int SW = $clog2(SEC_MAX + 1),
    localparam int MW = $clog2(MIN_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          dir,
    input  logic          cmd_start,
    input  logic          cmd_stop,
    input  logic          cmd_clear,
    input  logic          load_en,
    input  logic [MW-1:0] load_min,
    input  logic [SW-1:0] load_sec,
    output logic [SW-1:0] sec_bin,
    output logic [MW-1:0] min_bin,
    output logic [7:0]    sec_bcd,
    output logic [7:0]    min_bcd,
    output logic          running,
    output logic          wrap_p,
    output logic          expired_p,
    output logic [1:0]    state_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [MW-1:0] min_q, min_d;
    logic [PW-1:0] psc_q, psc_d;
    logic          wrap_d, expired_d;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        sec_d     = sec_q;
        min_d     = min_q;
        psc_d     = psc_q;
        wrap_d    = 1'b0;
        expired_d = 1'b0;

        if (cmd_clear) begin
            sec_d   = '0;
            min_d   = '0;
            psc_d   = '0;
            state_d = ST_IDLE;
        end else if (load_en) begin
            sec_d = (load_sec > SW'(SEC_MAX)) ? SW'(SEC_MAX) : load_sec;
            min_d = (load_min > MW'(MIN_MAX)) ? MW'(MIN_MAX) : load_min;
            psc_d = '0;
            if (state_q == ST_DONE) state_d = ST_IDLE;
        end else if (cmd_stop) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else if (cmd_start) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSE) state_d = ST_RUN;
        end else if (tick && state_q == ST_RUN) begin
            if (psc_q != PW'(TICK_DIV - 1)) begin
                psc_d = psc_q + 1'b1;
            end else begin
                psc_d = '0;
                if (!dir) begin
                    if (sec_q < SW'(SEC_MAX)) begin
                        sec_d = sec_q + 1'b1;
                    end else if (min_q < MW'(MIN_MAX)) begin
                        sec_d = '0;
                        min_d = min_q + 1'b1;
                    end else begin
                        sec_d  = '0;
                        min_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    if (sec_q != '0) begin
                        sec_d = sec_q - 1'b1;
                    end else if (min_q != '0) begin
                        sec_d = SW'(SEC_MAX);
                        min_d = min_q - 1'b1;
                    end else begin
                        // Count already at 00:00: hold it and expire.
                        state_d   = ST_DONE;
                        expired_d = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sec_q     <= '0;
            min_q     <= '0;
            psc_q     <= '0;
            wrap_p    <= 1'b0;
            expired_p <= 1'b0;
            sec_bcd   <= '0;
            min_bcd   <= '0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            psc_q     <= psc_d;
            wrap_p    <= wrap_d;
            expired_p <= expired_d;
            sec_bcd   <= to_bcd(7'(sec_q));
            min_bcd   <= to_bcd(7'(min_q));
        end
    end

    assign sec_bin = sec_q;
    assign min_bin = min_q;
    assign running = (state_q == ST_RUN);
    assign state_o = state_q;

endmodule

// File: tb/tb_mmss_timer_core.sv
// Directed bench for mmss_timer_core: three instances (default, MIN_MAX=1,
// TICK_DIV=4) share one stimulus bus; each check targets the relevant instance.
module tb_mmss_timer_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, dir, cmd_start, cmd_stop, cmd_clear, load_en;
    logic [6:0] load_min;
    logic [5:0] load_sec;

    logic [5:0] a_sec, b_sec, c_sec;
    logic [6:0] a_min, c_min;
    logic [0:0] b_min;
    logic [7:0] a_sbcd, a_mbcd, b_sbcd, b_mbcd, c_sbcd, c_mbcd;
    logic       a_run, a_wrap, a_exp, b_run, b_wrap, b_exp, c_run, c_wrap, c_exp;
    logic [1:0] a_st, b_st, c_st;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmss_timer_core #(.SEC_MAX(59), .MIN_MAX(99), .TICK_DIV(1)) u_a (
        .clk(clk), .rst(rst), .tick(tick), .dir(dir), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .load_en(load_en),
        .load_min(load_min), .load_sec(load_sec), .sec_bin(a_sec), .min_bin(a_min),
        .sec_bcd(a_sbcd), .min_bcd(a_mbcd), .running(a_run), .wrap_p(a_wrap),
        .expired_p(a_exp), .state_o(a_st)
    );

    mmss_timer_core #(.SEC_MAX(59), .MIN_MAX(1), .TICK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .dir(dir), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .load_en(load_en),
        .load_min(load_min[0:0]), .load_sec(load_sec), .sec_bin(b_sec), .min_bin(b_min),
        .sec_bcd(b_sbcd), .min_bcd(b_mbcd), .running(b_run), .wrap_p(b_wrap),
        .expired_p(b_exp), .state_o(b_st)
    );

    mmss_timer_core #(.SEC_MAX(59), .MIN_MAX(99), .TICK_DIV(4)) u_c (
        .clk(clk), .rst(rst), .tick(tick), .dir(dir), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .load_en(load_en),
        .load_min(load_min), .load_sec(load_sec), .sec_bin(c_sec), .min_bin(c_min),
        .sec_bcd(c_sbcd), .min_bcd(c_mbcd), .running(c_run), .wrap_p(c_wrap),
        .expired_p(c_exp), .state_o(c_st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // All drivers change inputs just after a falling edge and return one cycle later.
    task automatic do_clear();
        cmd_clear = 1'b1; @(negedge clk); cmd_clear = 1'b0;
    endtask

    task automatic do_start();
        cmd_start = 1'b1; @(negedge clk); cmd_start = 1'b0;
    endtask

    task automatic do_stop();
        cmd_stop = 1'b1; @(negedge clk); cmd_stop = 1'b0;
    endtask

    task automatic do_load(input logic [6:0] m, input logic [5:0] s);
        load_min = m; load_sec = s; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 0; dir = 0; cmd_start = 0; cmd_stop = 0; cmd_clear = 0;
        load_en = 0; load_min = '0; load_sec = '0;

        #12;
        check("reset_bins",  {a_sec, a_min}, 0);
        check("reset_bcd",   {a_sbcd, a_mbcd}, 0);
        check("reset_flags", {a_run, a_wrap, a_exp, a_st}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: 61 up-steps -> 01:01, BCD one clock behind
        do_clear();
        dir = 1'b0;
        do_start();
        check("t1_running", a_run, 1);
        do_ticks(61);
        check("t1_sec_bin", a_sec, 1);
        check("t1_min_bin", a_min, 1);
        check("t1_sec_bcd_lag", a_sbcd, 8'h00);
        check("t1_min_bcd_lag", a_mbcd, 8'h01);
        @(negedge clk);
        check("t1_sec_bcd", a_sbcd, 8'h01);
        check("t1_min_bcd", a_mbcd, 8'h01);

        // 2: wrap on MIN_MAX=1 instance; default instance carries to 02:00
        do_clear();
        do_load(7'd1, 6'd59);
        check("t2_load_b", {b_min, b_sec}, {1'b1, 6'd59});
        do_start();
        do_ticks(1);
        check("t2_b_count", {b_min, b_sec}, 0);
        check("t2_b_wrap", b_wrap, 1);
        check("t2_b_run", b_run, 1);
        check("t2_a_count", {a_min, a_sec}, {7'd2, 6'd0});
        check("t2_a_nowrap", a_wrap, 0);
        @(negedge clk);
        check("t2_b_wrap_end", b_wrap, 0);
        check("t2_b_state", b_st, 1);

        // 3: count down to expiry, DONE holds
        do_clear();
        do_load(7'd0, 6'd2);
        dir = 1'b1;
        do_start();
        do_ticks(1);
        check("t3_sec1", a_sec, 1);
        do_ticks(1);
        check("t3_sec0", a_sec, 0);
        check("t3_still_run", a_st, 1);
        check("t3_no_exp_yet", a_exp, 0);
        do_ticks(1);
        check("t3_done", a_st, 3);
        check("t3_exp", a_exp, 1);
        check("t3_run_off", a_run, 0);
        check("t3_hold", {a_min, a_sec}, 0);
        @(negedge clk);
        check("t3_exp_end", a_exp, 0);
        do_ticks(3);
        check("t3_hold2", {a_min, a_sec}, 0);
        check("t3_no_reexp", a_exp, 0);
        do_start();
        check("t3_start_ign", a_st, 3);
        do_load(7'd0, 6'd5);
        check("t3_load_idle", a_st, 0);
        check("t3_load_sec", a_sec, 5);
        do_clear();
        check("t3_clear", {a_st, a_sec}, 0);
        do_start();
        check("t3_restart", a_st, 1);

        // 4: TICK_DIV=4 prescaler survives pause
        do_clear();
        dir = 1'b0;
        do_start();
        do_ticks(10);
        check("t4_c_sec", c_sec, 2);
        check("t4_a_sec", a_sec, 10);
        do_stop();
        check("t4_pause", c_st, 2);
        check("t4_pause_run", c_run, 0);
        do_ticks(8);
        check("t4_paused_sec", c_sec, 2);
        do_start();
        check("t4_resume", c_st, 1);
        do_ticks(1);
        check("t4_psc3", c_sec, 2);
        do_ticks(1);
        check("t4_step", c_sec, 3);

        // 5: priority and saturation
        load_min = 7'd3; load_sec = 6'd3;
        cmd_clear = 1'b1; load_en = 1'b1; tick = 1'b1;
        @(negedge clk);
        cmd_clear = 1'b0; load_en = 1'b0; tick = 1'b0;
        check("t5_clear_wins", {a_min, a_sec}, 0);
        check("t5_clear_idle", a_st, 0);
        do_start();
        do_ticks(3);
        load_min = 7'd120; load_sec = 6'd63; load_en = 1'b1; tick = 1'b1;
        @(negedge clk);
        load_en = 1'b0; tick = 1'b0;
        check("t5_sat_sec", a_sec, 59);
        check("t5_sat_min", a_min, 99);
        check("t5_load_keep_run", a_st, 1);
        cmd_stop = 1'b1; cmd_start = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0; cmd_start = 1'b0;
        check("t5_stop_wins", a_st, 2);
        cmd_start = 1'b1; tick = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; tick = 1'b0;
        check("t5_start_drop_tick", {a_st, a_min, a_sec}, {2'd1, 7'd99, 6'd59});
        do_ticks(1);
        check("t5_a_wrap_cnt", {a_min, a_sec}, 0);
        check("t5_a_wrap", a_wrap, 1);

        // 6: asynchronous reset mid-run at 12:34
        do_clear();
        do_load(7'd12, 6'd34);
        do_start();
        @(negedge clk);
        check("t6_pre_bcd", {a_mbcd, a_sbcd}, 16'h1234);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_bins", {a_sec, a_min}, 0);
        check("t6_rst_bcd", {a_sbcd, a_mbcd}, 0);
        check("t6_rst_flags", {a_run, a_wrap, a_exp, a_st}, 0);
        check("t6_rst_others", {b_st, c_st, c_sec}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_pulses", {a_wrap, a_exp, a_st}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
